sample_acquisition_az: RTL and testbench
========================================

Name: sample_acquisition_az

Overview:
- Auto-zero sample acquisition sequencer.
- Drives the azmux, the precharge switch and the ADC measurement trigger so that each conversion pair is one signal (HI) measurement and one zero (LO) measurement. Each phase is preceded by a precharge interval.
- Sits between the register_set parameter registers and the mode/AF output mux, alongside sample_acquisition_pc, as a selectable mode.
- Raises meas_complete after every completed HI/LO pair.

Parameters:
- CNT_W, 24, width of the precharge clock counter.
- AZMUX_W, 4, width of the azmux select code.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- arm_i  in  1  level; 1 = run continuously, 0 = stop/idle.
- p_clk_count_precharge_i  in  CNT_W  precharge duration, in clk cycles.
- p_azmux_hi_i  in  AZMUX_W  azmux code for the signal (HI) phase.
- p_azmux_lo_i  in  AZMUX_W  azmux code for the zero (LO) phase.
- adc_measure_valid_i  in  1  one-cycle pulse from the ADC when a conversion finishes.
- adc_measure_trig_o  out  1  one-cycle pulse that starts an ADC conversion.
- sw_pc_ctl_o  out  1  precharge switch; 0 = precharge path, 1 = signal path.
- azmux_o  out  AZMUX_W  azmux drive.
- meas_complete_o  out  1  one-cycle pulse when a HI/LO pair completes.
- status_o  out  3  current state encoding.
- last_phase_lo_o  out  1  1 = the most recent valid conversion was the LO phase.
- led0_o  out  1  toggles on each meas_complete.
- monitor_o  out  8  {status_o, adc_measure_valid_i, adc_measure_trig_o, sw_pc_ctl_o, meas_complete_o, 1'b0}.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, counter 0, latched parameters 0.
- States and encodings: IDLE=0, PC_HI=1, MEAS_HI=2, PC_LO=3, MEAS_LO=4. Encodings 5-7 are unused; if ever reached, go to IDLE on the next clock.
- IDLE:
  - azmux_o = latched lo code, sw_pc_ctl_o = 0, trig = 0.
  - When arm_i = 1, latch p_clk_count_precharge_i, p_azmux_hi_i and p_azmux_lo_i, then go to PC_HI.
  - Parameter changes while running are ignored until the next IDLE exit.
- PC_HI:
  - azmux_o = hi, sw_pc_ctl_o = 0.
  - Lasts exactly max(N,1) cycles, where N is the latched count; N = 0 is treated as 1.
  - Then go to MEAS_HI.
- MEAS_HI:
  - azmux_o = hi, sw_pc_ctl_o = 1.
  - adc_measure_trig_o = 1 only on the first cycle in the state.
  - Wait for adc_measure_valid_i. A valid in the trigger cycle itself is ignored.
  - On valid: last_phase_lo_o = 0, go to PC_LO.
- PC_LO: same as PC_HI but with azmux_o = lo; then go to MEAS_LO.
- MEAS_LO:
  - Same as MEAS_HI with azmux_o = lo.
  - On valid: last_phase_lo_o = 1, meas_complete_o pulses for 1 cycle (the cycle after valid), led0_o toggles.
  - Then go to PC_HI if arm_i = 1, else IDLE.
- Disarm: if arm_i = 0 in any non-IDLE state, go to IDLE on the next clock.
  - Any in-flight conversion is abandoned.
  - No meas_complete is produced, even if valid arrives in the same cycle as the disarm (disarm wins).
- adc_measure_valid_i outside MEAS_* is ignored. There is no timeout; MEAS_* waits indefinitely and exits only via valid or disarm.
- Latency:
  - arm rising edge to first trig: 1 + max(N,1) cycles.
  - valid to the next trig: 1 + max(N,1) cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encodings SA_AZ_IDLE..SA_AZ_MEAS_LO, 3 bits;
  - the status bit layout;
  - constant SA_AZ_STATUS_W = 3, shared with register_set for the status readback.
- One natural sub-module: sa_precharge_counter. It is a loadable down-counter with a done flag and implements the max(N,1) rule; it is reused by sample_acquisition_pc.

Test Plan:
1. N=3, hi=4'b0001, lo=4'b0010, arm=1; ADC model returns valid 10 cycles after trig -> sw_pc_ctl_o low for 3 cycles, trig pulse with azmux_o=0001; after valid, 3 precharge cycles, trig with azmux_o=0010; meas_complete pulse 1 cycle after LO valid; loop repeats.
2. N=0 -> each precharge phase lasts exactly 1 cycle; trig 2 cycles after arm rising.
3. Drop arm during MEAS_HI, with valid in the same cycle -> IDLE next cycle, no meas_complete, azmux_o=lo, last_phase_lo_o unchanged.
4. Change p_azmux_hi_i mid-run -> azmux_o keeps the old code until a disarm/re-arm cycle, then the new code appears.
5. Assert reset_n low mid-PC_LO asynchronously -> all outputs 0 immediately (before the next clock edge), state IDLE; after release with arm=1, restarts at PC_HI.
6. Spurious valid pulses in IDLE, PC_*, and in the trigger cycle -> ignored; state and counters unaffected.

Source files
------------

// File: rtl/sample_acquisition_az_pkg.sv
// Shared definitions for the auto-zero acquisition sequencer: state codes,
// status width and the monitor bus bit layout.
package sample_acquisition_az_pkg;

  localparam int SA_AZ_STATUS_W = 3;

  localparam logic [SA_AZ_STATUS_W-1:0] SA_AZ_IDLE    = 3'd0;
  localparam logic [SA_AZ_STATUS_W-1:0] SA_AZ_PC_HI   = 3'd1;
  localparam logic [SA_AZ_STATUS_W-1:0] SA_AZ_MEAS_HI = 3'd2;
  localparam logic [SA_AZ_STATUS_W-1:0] SA_AZ_PC_LO   = 3'd3;
  localparam logic [SA_AZ_STATUS_W-1:0] SA_AZ_MEAS_LO = 3'd4;

  // Monitor bus layout: {status[7:5], valid[4], trig[3], sw_pc[2], complete[1], 0}
  localparam int SA_AZ_MON_STATUS_LSB = 5;
  localparam int SA_AZ_MON_VALID      = 4;
  localparam int SA_AZ_MON_TRIG       = 3;
  localparam int SA_AZ_MON_SW_PC      = 2;
  localparam int SA_AZ_MON_COMPLETE   = 1;

  function automatic logic sa_az_is_meas(input logic [SA_AZ_STATUS_W-1:0] s);
    return (s == SA_AZ_MEAS_HI) || (s == SA_AZ_MEAS_LO);
  endfunction

  function automatic logic sa_az_is_pc(input logic [SA_AZ_STATUS_W-1:0] s);
    return (s == SA_AZ_PC_HI) || (s == SA_AZ_PC_LO);
  endfunction

endpackage

// File: rtl/sample_acquisition_az_precharge_counter.sv
// Loadable precharge down-counter. A load of N gives a done flag after
// exactly max(N,1) cycles of the owning state.
module sa_precharge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             en_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Loading N-1 makes the first state cycle count as one; N=0 clamps to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (count_i == '0) ? '0 : count_i - ONE;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sample_acquisition_az.sv
// Auto-zero acquisition sequencer: alternates precharged HI and LO
// conversions and pulses meas_complete after each pair.
module sample_acquisition_az
  import sample_acquisition_az_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int AZMUX_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      arm_i,
  input  logic [CNT_W-1:0]          p_clk_count_precharge_i,
  input  logic [AZMUX_W-1:0]        p_azmux_hi_i,
  input  logic [AZMUX_W-1:0]        p_azmux_lo_i,
  input  logic                      adc_measure_valid_i,
  output logic                      adc_measure_trig_o,
  output logic                      sw_pc_ctl_o,
  output logic [AZMUX_W-1:0]        azmux_o,
  output logic                      meas_complete_o,
  output logic [SA_AZ_STATUS_W-1:0] status_o,
  output logic                      last_phase_lo_o,
  output logic                      led0_o,
  output logic [7:0]                monitor_o
);

  logic [SA_AZ_STATUS_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]          n_q, n_d;
  logic [AZMUX_W-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic                      lpl_q, lpl_d;
  logic                      led_q, led_d;
  logic                      trig_q, trig_d;
  logic                      sw_q, sw_d;
  logic                      mc_q, mc_d;
  logic [AZMUX_W-1:0]        az_q, az_d;
  logic [7:0]                mon_q, mon_d;
  logic                      valid_ok;
  logic                      pc_done;
  logic                      pc_load;
  logic                      pc_en;

  // trig_q is high exactly in the first MEAS cycle, so a valid there is dropped.
  assign valid_ok = adc_measure_valid_i && !trig_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    lpl_d   = lpl_q;
    led_d   = led_q;
    mc_d    = 1'b0;
    case (state_q)
      SA_AZ_IDLE: begin
        if (arm_i) begin
          n_d     = p_clk_count_precharge_i;
          hi_d    = p_azmux_hi_i;
          lo_d    = p_azmux_lo_i;
          state_d = SA_AZ_PC_HI;
        end
      end
      SA_AZ_PC_HI: begin
        if (!arm_i)       state_d = SA_AZ_IDLE;
        else if (pc_done) state_d = SA_AZ_MEAS_HI;
      end
      SA_AZ_MEAS_HI: begin
        if (!arm_i) begin
          state_d = SA_AZ_IDLE;
        end else if (valid_ok) begin
          lpl_d   = 1'b0;
          state_d = SA_AZ_PC_LO;
        end
      end
      SA_AZ_PC_LO: begin
        if (!arm_i)       state_d = SA_AZ_IDLE;
        else if (pc_done) state_d = SA_AZ_MEAS_LO;
      end
      SA_AZ_MEAS_LO: begin
        if (!arm_i) begin
          state_d = SA_AZ_IDLE;
        end else if (valid_ok) begin
          lpl_d   = 1'b1;
          mc_d    = 1'b1;
          led_d   = ~led_q;
          state_d = SA_AZ_PC_HI;
        end
      end
      default: state_d = SA_AZ_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up
  // with status_o in the same cycle.
  always_comb begin
    trig_d  = sa_az_is_meas(state_d) && (state_d != state_q);
    sw_d    = sa_az_is_meas(state_d);
    az_d    = ((state_d == SA_AZ_PC_HI) || (state_d == SA_AZ_MEAS_HI)) ? hi_d : lo_d;
    pc_load = sa_az_is_pc(state_d) && (state_d != state_q);
    pc_en   = sa_az_is_pc(state_q);
    mon_d   = {state_d, adc_measure_valid_i, trig_d, sw_d, mc_d, 1'b0};
  end

  sa_precharge_counter #(.CNT_W(CNT_W)) u_pc_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (pc_load),
    .count_i (n_d),
    .en_i    (pc_en),
    .done_o  (pc_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SA_AZ_IDLE;
      n_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      lpl_q   <= 1'b0;
      led_q   <= 1'b0;
      trig_q  <= 1'b0;
      sw_q    <= 1'b0;
      mc_q    <= 1'b0;
      az_q    <= '0;
      mon_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      lpl_q   <= lpl_d;
      led_q   <= led_d;
      trig_q  <= trig_d;
      sw_q    <= sw_d;
      mc_q    <= mc_d;
      az_q    <= az_d;
      mon_q   <= mon_d;
    end
  end

  assign adc_measure_trig_o = trig_q;
  assign sw_pc_ctl_o        = sw_q;
  assign azmux_o            = az_q;
  assign meas_complete_o    = mc_q;
  assign status_o           = state_q;
  assign last_phase_lo_o    = lpl_q;
  assign led0_o             = led_q;
  assign monitor_o          = mon_q;

endmodule

// File: tb/tb_sample_acquisition_az.sv
// Directed bench for sample_acquisition_az: each task walks one scenario
// cycle by cycle against hand-computed output vectors.
module tb_sample_acquisition_az;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        arm_i = 1'b0;
  logic [23:0] p_clk_count_precharge_i = '0;
  logic [3:0]  p_azmux_hi_i = '0;
  logic [3:0]  p_azmux_lo_i = '0;
  logic        adc_measure_valid_i = 1'b0;
  logic        adc_measure_trig_o;
  logic        sw_pc_ctl_o;
  logic [3:0]  azmux_o;
  logic        meas_complete_o;
  logic [2:0]  status_o;
  logic        last_phase_lo_o;
  logic        led0_o;
  logic [7:0]  monitor_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] obs;
  logic [11:0] exp_v;

  sample_acquisition_az dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .arm_i                   (arm_i),
    .p_clk_count_precharge_i (p_clk_count_precharge_i),
    .p_azmux_hi_i            (p_azmux_hi_i),
    .p_azmux_lo_i            (p_azmux_lo_i),
    .adc_measure_valid_i     (adc_measure_valid_i),
    .adc_measure_trig_o      (adc_measure_trig_o),
    .sw_pc_ctl_o             (sw_pc_ctl_o),
    .azmux_o                 (azmux_o),
    .meas_complete_o         (meas_complete_o),
    .status_o                (status_o),
    .last_phase_lo_o         (last_phase_lo_o),
    .led0_o                  (led0_o),
    .monitor_o               (monitor_o)
  );

  always #5 clk = ~clk;

  // Observed vector: {status, trig, sw_pc, azmux, complete, last_lo, led}
  assign obs = {status_o, adc_measure_trig_o, sw_pc_ctl_o, azmux_o,
                meas_complete_o, last_phase_lo_o, led0_o};

  function automatic logic [11:0] pack(input logic [2:0] st, input logic trig,
                                       input logic sw, input logic [3:0] az,
                                       input logic mc, input logic lpl,
                                       input logic led);
    return {st, trig, sw, az, mc, lpl, led};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++; if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_outputs: got %h exp %h", obs, 12'h000); end
    step();
    step();
    n_checks++; if (monitor_o !== 8'h00) begin n_fail++; $display("FAIL reset_monitor: got %h exp %h", monitor_o, 8'h00); end
    n_checks++; if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_held: got %h exp %h", obs, 12'h000); end
    #3 reset_n = 1'b1;
    step();
    n_checks++; if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_idle_after: got %h exp %h", obs, 12'h000); end
  endtask

  task automatic test_basic();
    p_clk_count_precharge_i = 24'd3; p_azmux_hi_i = 4'h1; p_azmux_lo_i = 4'h2;
    arm_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_v = (i < 4) ? pack(3'd1, 0, 0, 4'h1, 0, 0, 0) : pack(3'd2, 1, 1, 4'h1, 0, 0, 0);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_hi_pc_%0d: got %h exp %h", i, obs, exp_v); end
    end
    n_checks++; if (monitor_o !== 8'h4C) begin n_fail++; $display("FAIL basic_monitor_trig: got %h exp %h", monitor_o, 8'h4C); end
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_v = pack(3'd2, 0, 1, 4'h1, 0, 0, 0);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_meas_hi_wait_%0d: got %h exp %h", i, obs, exp_v); end
    end
    adc_measure_valid_i = 1'b1;
    step();
    adc_measure_valid_i = 1'b0;
    exp_v = pack(3'd3, 0, 0, 4'h2, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_pc_lo_entry: got %h exp %h", obs, exp_v); end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = (i < 3) ? pack(3'd3, 0, 0, 4'h2, 0, 0, 0) : pack(3'd4, 1, 1, 4'h2, 0, 0, 0);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_lo_pc_%0d: got %h exp %h", i, obs, exp_v); end
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_v = pack(3'd4, 0, 1, 4'h2, 0, 0, 0);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_meas_lo_wait_%0d: got %h exp %h", i, obs, exp_v); end
    end
    adc_measure_valid_i = 1'b1;
    step();
    adc_measure_valid_i = 1'b0;
    exp_v = pack(3'd1, 0, 0, 4'h1, 1, 1, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_complete: got %h exp %h", obs, exp_v); end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = (i < 3) ? pack(3'd1, 0, 0, 4'h1, 0, 1, 1) : pack(3'd2, 1, 1, 4'h1, 0, 1, 1);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_loop_pc_%0d: got %h exp %h", i, obs, exp_v); end
    end
    arm_i = 1'b0;
    step();
    exp_v = pack(3'd0, 0, 0, 4'h2, 0, 1, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic_disarm: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_n_zero();
    p_clk_count_precharge_i = 24'd0; p_azmux_hi_i = 4'h5; p_azmux_lo_i = 4'hA;
    arm_i = 1'b1;
    step();
    exp_v = pack(3'd1, 0, 0, 4'h5, 0, 1, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_pc_hi: got %h exp %h", obs, exp_v); end
    step();
    exp_v = pack(3'd2, 1, 1, 4'h5, 0, 1, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_trig_hi: got %h exp %h", obs, exp_v); end
    step();
    adc_measure_valid_i = 1'b1;
    step();
    adc_measure_valid_i = 1'b0;
    exp_v = pack(3'd3, 0, 0, 4'hA, 0, 0, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_pc_lo: got %h exp %h", obs, exp_v); end
    step();
    exp_v = pack(3'd4, 1, 1, 4'hA, 0, 0, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_trig_lo: got %h exp %h", obs, exp_v); end
    adc_measure_valid_i = 1'b1;
    step();
    exp_v = pack(3'd4, 0, 1, 4'hA, 0, 0, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_trig_cycle_valid: got %h exp %h", obs, exp_v); end
    step();
    adc_measure_valid_i = 1'b0;
    exp_v = pack(3'd1, 0, 0, 4'h5, 1, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_complete: got %h exp %h", obs, exp_v); end
    step();
    exp_v = pack(3'd2, 1, 1, 4'h5, 0, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_loop_trig: got %h exp %h", obs, exp_v); end
    arm_i = 1'b0;
    step();
    exp_v = pack(3'd0, 0, 0, 4'hA, 0, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL nzero_disarm: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_disarm_meas();
    p_clk_count_precharge_i = 24'd2; p_azmux_hi_i = 4'h3; p_azmux_lo_i = 4'hC;
    arm_i = 1'b1;
    step();
    step();
    step();
    exp_v = pack(3'd2, 1, 1, 4'h3, 0, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL disarm_trig: got %h exp %h", obs, exp_v); end
    step();
    adc_measure_valid_i = 1'b1;
    arm_i = 1'b0;
    step();
    adc_measure_valid_i = 1'b0;
    exp_v = pack(3'd0, 0, 0, 4'hC, 0, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL disarm_wins: got %h exp %h", obs, exp_v); end
    step();
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL disarm_stays_idle: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_param_change();
    p_clk_count_precharge_i = 24'd1; p_azmux_hi_i = 4'h6; p_azmux_lo_i = 4'h9;
    arm_i = 1'b1;
    step();
    exp_v = pack(3'd1, 0, 0, 4'h6, 0, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL param_pc_hi: got %h exp %h", obs, exp_v); end
    p_azmux_hi_i = 4'h7;
    p_clk_count_precharge_i = 24'd5;
    step();
    exp_v = pack(3'd2, 1, 1, 4'h6, 0, 1, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL param_old_hi_trig: got %h exp %h", obs, exp_v); end
    step();
    adc_measure_valid_i = 1'b1;
    step();
    adc_measure_valid_i = 1'b0;
    step();
    exp_v = pack(3'd4, 1, 1, 4'h9, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL param_old_n_lo_trig: got %h exp %h", obs, exp_v); end
    step();
    adc_measure_valid_i = 1'b1;
    step();
    adc_measure_valid_i = 1'b0;
    exp_v = pack(3'd1, 0, 0, 4'h6, 1, 1, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL param_loop_old_hi: got %h exp %h", obs, exp_v); end
    arm_i = 1'b0;
    step();
    arm_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_v = (i < 6) ? pack(3'd1, 0, 0, 4'h7, 0, 1, 1) : pack(3'd2, 1, 1, 4'h7, 0, 1, 1);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL param_new_%0d: got %h exp %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid_pc_lo();
    adc_measure_valid_i = 1'b1;
    step();
    exp_v = pack(3'd2, 0, 1, 4'h7, 0, 1, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_trig_valid_ignored: got %h exp %h", obs, exp_v); end
    step();
    adc_measure_valid_i = 1'b0;
    step();
    exp_v = pack(3'd3, 0, 0, 4'h9, 0, 0, 1);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_in_pc_lo: got %h exp %h", obs, exp_v); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (obs !== 12'h000) begin n_fail++; $display("FAIL rst_async_outputs: got %h exp %h", obs, 12'h000); end
    n_checks++; if (monitor_o !== 8'h00) begin n_fail++; $display("FAIL rst_async_monitor: got %h exp %h", monitor_o, 8'h00); end
    #2 reset_n = 1'b1;
    step();
    exp_v = pack(3'd1, 0, 0, 4'h7, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_restart_pc_hi: got %h exp %h", obs, exp_v); end
    arm_i = 1'b0;
    step();
    exp_v = pack(3'd0, 0, 0, 4'h9, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_disarm: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_spurious();
    p_clk_count_precharge_i = 24'd2; p_azmux_hi_i = 4'h1; p_azmux_lo_i = 4'h2;
    adc_measure_valid_i = 1'b1;
    step();
    exp_v = pack(3'd0, 0, 0, 4'h9, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL spur_idle: got %h exp %h", obs, exp_v); end
    arm_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = (i < 3) ? pack(3'd1, 0, 0, 4'h1, 0, 0, 0) : pack(3'd2, 1, 1, 4'h1, 0, 0, 0);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL spur_pc_hi_%0d: got %h exp %h", i, obs, exp_v); end
    end
    step();
    exp_v = pack(3'd2, 0, 1, 4'h1, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL spur_trig_cycle: got %h exp %h", obs, exp_v); end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = (i < 3) ? pack(3'd3, 0, 0, 4'h2, 0, 0, 0) : pack(3'd4, 1, 1, 4'h2, 0, 0, 0);
      n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL spur_pc_lo_%0d: got %h exp %h", i, obs, exp_v); end
    end
    adc_measure_valid_i = 1'b0;
    arm_i = 1'b0;
    step();
    exp_v = pack(3'd0, 0, 0, 4'h2, 0, 0, 0);
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL spur_disarm: got %h exp %h", obs, exp_v); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_n_zero();
    test_disarm_meas();
    test_param_change();
    test_reset_mid_pc_lo();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
